// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and state type for the cache refill path.
// The cache array and data-side controller import this package as well.
package cache_fill_fsm_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int WORD_BYTES  = 2;
  localparam int OFFSET_W    = $clog2(BLOCK_WORDS * WORD_BYTES);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Byte-offset width of a block holding the given number of 16-bit words.
  function automatic int offsetWidth(input int words);
    return $clog2(words * WORD_BYTES);
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/memory/array signal bundle between the refill controller and its neighbours.
// The master side is the refill controller; the slave side is cache lookup plus memory.
interface cache_fill_fsm_if #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8
);

  localparam int SEL_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              mem_data_valid;
  logic [15:0]       mem_data;
  logic              fsm_busy;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic              write_data_array;
  logic              write_tag_array;
  logic [15:0]       data_out;
  logic [SEL_W-1:0]  word_sel;
  logic [ADDR_W-1:0] block_addr;

  modport master (
    input  miss_detected, miss_address, mem_data_valid, mem_data,
    output fsm_busy, mem_read, mem_addr, write_data_array, write_tag_array,
           data_out, word_sel, block_addr
  );

  modport slave (
    output miss_detected, miss_address, mem_data_valid, mem_data,
    input  fsm_busy, mem_read, mem_addr, write_data_array, write_tag_array,
           data_out, word_sel, block_addr
  );

endinterface

// File: rtl/cache_fill_fsm_word_counter.sv
// Clear/increment counter that saturates at MAX; clear takes priority over increment.
module word_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss refill controller: issues BLOCK_WORDS sequential word reads and
// streams the returned words into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = cache_fill_fsm_pkg::BLOCK_WORDS,
  parameter int ADDR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus_io
);

  import cache_fill_fsm_pkg::*;

  localparam int SEL_W   = $clog2(BLOCK_WORDS);
  localparam int ISSUE_W = $clog2(BLOCK_WORDS + 1);
  localparam int OFF_W   = offsetWidth(BLOCK_WORDS);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFF_W) - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] block_addr_q, block_addr_d;
  logic [ISSUE_W-1:0] issueCnt;
  logic [SEL_W-1:0]  recvCnt;
  logic [SEL_W-1:0]  issueIdx;
  logic              startFill;
  logic              issueInc;
  logic              recvInc;
  logic              lastWord;

  word_counter #(.MAX(BLOCK_WORDS), .W(ISSUE_W)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (startFill),
    .inc_i (issueInc),
    .cnt_o (issueCnt)
  );

  word_counter #(.MAX(BLOCK_WORDS - 1), .W(SEL_W)) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (startFill),
    .inc_i (recvInc),
    .cnt_o (recvCnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      block_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      block_addr_q <= block_addr_d;
    end
  end

  // Issue and receive proceed independently; the fill ends on the last received word.
  always_comb begin
    state_d      = state_q;
    block_addr_d = block_addr_q;
    startFill    = 1'b0;
    issueInc     = 1'b0;
    recvInc      = 1'b0;
    lastWord     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_io.miss_detected) begin
          startFill    = 1'b1;
          block_addr_d = bus_io.miss_address & ~OFFSET_MASK;
          state_d      = FILL;
        end
      end
      FILL: begin
        issueInc = (issueCnt < ISSUE_W'(BLOCK_WORDS));
        recvInc  = bus_io.mem_data_valid;
        lastWord = bus_io.mem_data_valid && (recvCnt == SEL_W'(BLOCK_WORDS - 1));
        if (lastWord) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Once all requests are out, the address parks on the final word of the block.
  assign issueIdx = (issueCnt == ISSUE_W'(BLOCK_WORDS)) ? SEL_W'(BLOCK_WORDS - 1)
                                                        : issueCnt[SEL_W-1:0];

  assign bus_io.fsm_busy         = (state_q == FILL);
  assign bus_io.mem_read         = issueInc;
  assign bus_io.mem_addr         = block_addr_q + ADDR_W'({issueIdx, 1'b0});
  assign bus_io.write_data_array = recvInc;
  assign bus_io.write_tag_array  = lastWord;
  assign bus_io.data_out         = bus_io.mem_data;
  assign bus_io.word_sel         = recvCnt;
  assign bus_io.block_addr       = block_addr_q;

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that refills one 16-byte cache block from pipelined main memory. Sits directly upstream of the CPU's fetch/memory stage, between the cache arrays and main memory. On a miss it issues eight sequential word reads and streams returned words into the data array. It then writes the tag and releases the pipeline stall.

## Interface

**Parameters**
- `BLOCK_WORDS`, default 8: words per block; power of two.
- `ADDR_W`, default 16: byte-address width.

**Ports**
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `miss_detected` input 1: cache lookup missed this cycle; sampled only in IDLE.
- `miss_address` input ADDR_W: byte address of the missing access.
- `mem_data_valid` input 1: `mem_data` carries a returned word this cycle.
- `mem_data` input 16: returned memory word.
- `fsm_busy` output 1: high while refill is in progress; CPU stalls on `fsm_busy | miss_detected`.
- `mem_read` output 1: issue a read of `mem_addr` this cycle.
- `mem_addr` output ADDR_W: memory request address.
- `write_data_array` output 1: write `data_out` into word `word_sel` of the block at `block_addr`.
- `write_tag_array` output 1: one-cycle pulse to write the tag and set the valid bit for `block_addr`.
- `data_out` output 16: equals `mem_data` when `write_data_array` is high.
- `word_sel` output log2(BLOCK_WORDS): word index within the block for the current data write.
- `block_addr` output ADDR_W: latched block base address (`miss_address` with bits [3:0] cleared).

## Operation

- **States**
  - IDLE: `miss_detected=1` latches `block_addr`, clears both counters, and moves to FILL.
  - FILL: issue and receive words; moves to IDLE on the cycle the last word is received.
- **Counters**
  - `issue_cnt` (0..BLOCK_WORDS) counts requests sent.
  - `recv_cnt` (0..BLOCK_WORDS-1) counts words received.
- **Issue (FILL)**
  - `mem_read=1` while `issue_cnt<BLOCK_WORDS`.
  - `mem_addr = block_addr + 2*issue_cnt`.
  - `issue_cnt` increments every cycle until it saturates at BLOCK_WORDS.
  - When saturated, `mem_read=0` and `mem_addr` holds its last value.
- **Receive (FILL)**
  - When `mem_data_valid=1`: `write_data_array=1`, `word_sel=recv_cnt`, and `recv_cnt` increments.
  - When `recv_cnt==BLOCK_WORDS-1` and valid: `write_tag_array=1` in the same cycle, and the next state is IDLE.
  - Receives may overlap issues in the same cycle.
- **Outputs**
  - `fsm_busy = (state==FILL)`.
  - `mem_read`, `write_data_array`, `write_tag_array` are combinational from state and counters, and are 0 in IDLE.
- **Arithmetic:** address adds are modulo 2^ADDR_W. Bits [3:0] of `block_addr` are 0, so bits [15:4] never carry within a block; for example, base 0xFFF0 ends at 0xFFFE.
- **Boundary conditions**
  - `mem_data_valid` in IDLE is ignored; no writes occur.
  - `miss_detected` during FILL is ignored; `block_addr` is not re-latched.
  - A miss present on the first IDLE cycle after a fill starts a new fill the following cycle. There is at least one IDLE cycle between fills.
  - `rst` mid-fill returns to IDLE immediately: counters and `block_addr` go to 0, and no tag write occurs. The partially written block stays invalid.

## Timing

- **Reset values:** state=IDLE, `block_addr=0`, counters=0. All outputs are 0, except `data_out`, which follows `mem_data`.
- **Reference sequence** (miss at cycle 0, memory latency 4, one word per cycle):
  - Cycles 1–8: FILL, requests issued.
  - Cycles 5–12: data valid.
  - Cycle 12: `write_tag_array` pulses.
  - Cycle 13: IDLE.
  - `fsm_busy` is high for cycles 1–12, i.e. 12 cycles.
- **General latency:** BLOCK_WORDS + L cycles of busy, for memory latency L with no bubbles. Gaps in `mem_data_valid` extend FILL by one cycle per gap.

## Structure

- **Shared package:** `BLOCK_WORDS`, the offset width constant, and the state type (IDLE, FILL). The package is reused by the cache array and the data-side controller.
- **Sub-module:** one natural sub-module, `word_counter`, a saturating clear/increment counter. It is instantiated twice, for `issue_cnt` and `recv_cnt`.

## Test plan

- **Basic refill:** miss at 0x1236 with latency-4 memory.
  - Addresses 0x1230, 0x1232, …, 0x123E are issued in cycles 1–8.
  - Eight data writes occur with `word_sel` 0..7 and `block_addr`=0x1230.
  - `write_tag_array` occurs in cycle 12, and `fsm_busy` drops in cycle 13.
- **Bubbly returns:** `mem_data_valid` held low for 3 cycles mid-stream.
  - `fsm_busy` lasts 15 cycles and `word_sel` stays contiguous.
  - Exactly one tag pulse occurs.
- **Top-of-memory wrap:** miss at 0xFFFA.
  - Addresses run from 0xFFF0 to 0xFFFE.
  - `block_addr`=0xFFF0.
- **Ignored inputs:**
  - `miss_detected`=1 at 0x4000 during a fill of 0x2000: the fill completes at 0x2000.
  - Spurious `mem_data_valid` in IDLE: no writes occur.
- **Reset mid-fill:** assert `rst` after the 3rd received word.
  - All outputs go to 0 asynchronously, with no tag pulse.
  - A new miss after reset is released refills from word 0.
- **Back-to-back misses:** `miss_detected` held high.
  - The second fill starts after exactly one IDLE cycle.
